// File: rtl/candidate_map_table_if.sv
// Bundle of candidate-list handshake, read-port and debug signals for candidate_map_table.
// The inverse lookup signals exist only when CANDMAP_INVERSE_EN is defined.
interface candidate_map_table_if #(
    parameter int BS = 16
);
    localparam int IW = $clog2(BS);
    localparam int CW = $clog2(BS + 1);

    // Accept handshake: a list transfers on a clock edge where in_valid && in_ready are both 1.
    // in_ready is high only in IDLE; in_valid in any other state is dropped, not queued.
    logic            in_valid;
    logic            in_ready;
    logic [0:BS-1]   candidate_list;
    logic            busy;
    logic            done;
    logic [CW-1:0]   map_count;
    logic            rd_en;
    logic [IW-1:0]   rd_addr;
    logic            rd_valid;
    logic [IW-1:0]   rd_data;
    logic [1:0]      state_dbg;
`ifdef CANDMAP_INVERSE_EN
    logic            inv_en;
    logic [IW-1:0]   inv_idx;
    logic            inv_valid;
    logic            inv_hit;
    logic [IW-1:0]   inv_slot;

    modport master (
        output in_valid, candidate_list, rd_en, rd_addr, inv_en, inv_idx,
        input  in_ready, busy, done, map_count, rd_valid, rd_data, state_dbg,
               inv_valid, inv_hit, inv_slot
    );
    modport slave (
        input  in_valid, candidate_list, rd_en, rd_addr, inv_en, inv_idx,
        output in_ready, busy, done, map_count, rd_valid, rd_data, state_dbg,
               inv_valid, inv_hit, inv_slot
    );
`else
    modport master (
        output in_valid, candidate_list, rd_en, rd_addr,
        input  in_ready, busy, done, map_count, rd_valid, rd_data, state_dbg
    );
    modport slave (
        input  in_valid, candidate_list, rd_en, rd_addr,
        output in_ready, busy, done, map_count, rd_valid, rd_data, state_dbg
    );
`endif
endinterface

// File: rtl/candidate_map_table.sv
// Multi-lane candidate mapping table: compacts a BS-bit mask into an ascending index table, LANES per cycle.
// Optional inverse (index -> slot) lookup is enabled by defining CANDMAP_INVERSE_EN.
module candidate_map_table #(
    parameter int BS    = 16,
    parameter int LANES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    candidate_map_table_if.slave  bus
);
    localparam int IW = $clog2(BS);
    localparam int CW = $clog2(BS + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_accept;
    logic [BS-1:0]   w_list;
    logic [BS-1:0]   r_rem_mask;
    logic [BS-1:0]   w_take;
    logic [BS-1:0]   w_rem_nxt;
    logic [CW-1:0]   r_map_count;
    logic [CW-1:0]   w_k;
    logic [IW-1:0]   r_table [BS];
    logic [LANES-1:0] w_lane_vld;
    logic [IW-1:0]   w_lane_idx  [LANES];
    logic [IW-1:0]   w_lane_slot [LANES];
    logic            r_rd_valid;
    logic [IW-1:0]   r_rd_data;

    always_comb begin
        w_list = '0;
        for (int i = 0; i < BS; i++) begin
            w_list[i] = bus.candidate_list[i];
        end
    end

    // Lane l takes the (l+1)th lowest set bit of the remaining mask.
    always_comb begin : compact
        int cnt;
        cnt        = 0;
        w_take     = '0;
        w_lane_vld = '0;
        w_k        = '0;
        for (int l = 0; l < LANES; l++) begin
            w_lane_idx[l]  = '0;
            w_lane_slot[l] = r_map_count[IW-1:0] + IW'(l);
        end
        for (int i = 0; i < BS; i++) begin
            if (r_rem_mask[i]) begin
                for (int l = 0; l < LANES; l++) begin
                    if (cnt == l) begin
                        w_lane_vld[l] = 1'b1;
                        w_lane_idx[l] = IW'(i);
                        w_take[i]     = 1'b1;
                        w_k           = w_k + CW'(1);
                    end
                end
                cnt = cnt + 1;
            end
        end
        w_rem_nxt = r_rem_mask & ~w_take;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (w_rem_nxt == '0) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_rem_mask  <= '0;
            r_map_count <= '0;
            for (int i = 0; i < BS; i++) begin
                r_table[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_rem_mask  <= w_list;
                r_map_count <= '0;
            end else if (r_state == ST_SCAN) begin
                r_rem_mask  <= w_rem_nxt;
                r_map_count <= r_map_count + w_k;
                for (int l = 0; l < LANES; l++) begin
                    if (w_lane_vld[l]) begin
                        r_table[w_lane_slot[l]] <= w_lane_idx[l];
                    end
                end
            end
        end
    end

    // Gating on map_count hides entries left over from an earlier list.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= bus.rd_en;
            if (bus.rd_en) begin
                r_rd_data <= (CW'(bus.rd_addr) < r_map_count) ? r_table[bus.rd_addr] : '0;
            end
        end
    end

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.busy      = (r_state == ST_SCAN) || (r_state == ST_DONE);
    assign bus.done      = (r_state == ST_DONE);
    assign bus.map_count = r_map_count;
    assign bus.rd_valid  = r_rd_valid;
    assign bus.rd_data   = r_rd_data;
    assign bus.state_dbg = r_state;

`ifdef CANDMAP_INVERSE_EN
    localparam int DEPTH = 1 << IW;

    logic [DEPTH-1:0] r_inv_map;
    logic [IW-1:0]    r_inv_tab [DEPTH];
    logic             r_inv_valid;
    logic             r_inv_hit;
    logic [IW-1:0]    r_inv_slot;

    always_ff @(posedge clk) begin
        if (rst || w_accept) begin
            r_inv_map <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_inv_tab[i] <= '0;
            end
        end else if (r_state == ST_SCAN) begin
            for (int l = 0; l < LANES; l++) begin
                if (w_lane_vld[l]) begin
                    r_inv_map[w_lane_idx[l]] <= 1'b1;
                    r_inv_tab[w_lane_idx[l]] <= w_lane_slot[l];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_inv_valid <= 1'b0;
            r_inv_hit   <= 1'b0;
            r_inv_slot  <= '0;
        end else begin
            r_inv_valid <= bus.inv_en;
            if (bus.inv_en) begin
                r_inv_hit  <= r_inv_map[bus.inv_idx];
                r_inv_slot <= r_inv_map[bus.inv_idx] ? r_inv_tab[bus.inv_idx] : '0;
            end
        end
    end

    assign bus.inv_valid = r_inv_valid;
    assign bus.inv_hit   = r_inv_hit;
    assign bus.inv_slot  = r_inv_slot;
`endif
endmodule

// File: tb/tb_candidate_map_table.sv
// Directed plus randomized bench for candidate_map_table against a queue-based model of the set-bit list.
module tb_candidate_map_table;
    localparam int BS    = 16;
    localparam int LANES = 4;
    localparam int IW    = $clog2(BS);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    candidate_map_table_if #(.BS(BS)) bus ();

    candidate_map_table #(.BS(BS), .LANES(LANES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [IW-1:0] exp_q[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Model: the table is simply the ascending list of set indices.
    task automatic build_model(input logic [0:BS-1] m);
        exp_q.delete();
        for (int i = 0; i < BS; i++) begin
            if (m[i]) exp_q.push_back(IW'(i));
        end
    endtask

    function automatic int exp_scans();
        int n;
        n = (exp_q.size() + LANES - 1) / LANES;
        return (n == 0) ? 1 : n;
    endfunction

    task automatic accept(input logic [0:BS-1] m);
        int cyc;
        cyc = 0;
        while (bus.in_ready !== 1'b1 && cyc < 50) begin
            step();
            cyc++;
        end
        check("ready_wait", {31'd0, bus.in_ready}, 32'd1);
        bus.in_valid       = 1'b1;
        bus.candidate_list = m;
        step();
        bus.in_valid       = 1'b0;
        bus.candidate_list = BS'($urandom);
        check("accept_busy", {31'd0, bus.busy}, 32'd1);
    endtask

    task automatic wait_done(input int exp_n);
        int cyc;
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 40) begin
            step();
            cyc++;
        end
        check("done_latency", cyc, exp_n);
        check("done_count", {27'd0, bus.map_count}, exp_q.size());
        check("done_not_ready", {31'd0, bus.in_ready}, 32'd0);
    endtask

    task automatic check_table();
        logic [IW-1:0] e;
        for (int a = 0; a < BS; a++) begin
            bus.rd_en   = 1'b1;
            bus.rd_addr = IW'(a);
            step();
            e = (a < exp_q.size()) ? exp_q[a] : '0;
            check("rd_data", {28'd0, bus.rd_data}, {28'd0, e});
        end
        check("rd_valid_hi", {31'd0, bus.rd_valid}, 32'd1);
        bus.rd_en = 1'b0;
        step();
        check("rd_valid_lo", {31'd0, bus.rd_valid}, 32'd0);
        check("count_hold", {27'd0, bus.map_count}, exp_q.size());
    endtask

    task automatic run_list(input logic [0:BS-1] m);
        build_model(m);
        accept(m);
        wait_done(exp_scans());
        check_table();
    endtask

`ifdef CANDMAP_INVERSE_EN
    task automatic inv_check(input logic [IW-1:0] idx);
        logic hit;
        logic [IW-1:0] slot;
        hit  = 1'b0;
        slot = '0;
        for (int j = 0; j < exp_q.size(); j++) begin
            if (exp_q[j] == idx) begin
                hit  = 1'b1;
                slot = IW'(j);
            end
        end
        bus.inv_en  = 1'b1;
        bus.inv_idx = idx;
        step();
        bus.inv_en = 1'b0;
        check("inv_valid", {31'd0, bus.inv_valid}, 32'd1);
        check("inv_hit", {31'd0, bus.inv_hit}, {31'd0, hit});
        check("inv_slot", {28'd0, bus.inv_slot}, {28'd0, slot});
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [0:BS-1] m;
        logic [0:BS-1] m2;
        logic [BS-1:0] r;
        int sel;

        rst                = 1'b1;
        bus.in_valid       = 1'b0;
        bus.candidate_list = '0;
        bus.rd_en          = 1'b0;
        bus.rd_addr        = '0;
`ifdef CANDMAP_INVERSE_EN
        bus.inv_en         = 1'b0;
        bus.inv_idx        = '0;
`endif
        step();
        step();
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_count", {27'd0, bus.map_count}, 32'd0);
        check("rst_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
        check("rst_rd_data", {28'd0, bus.rd_data}, 32'd0);
        rst = 1'b0;
        step();

        m = '0; m[1] = 1'b1; m[4] = 1'b1; m[9] = 1'b1;
        run_list(m);
        m = '1;
        run_list(m);
        m = '0;
        run_list(m);

        // New list offered during SCAN must be ignored; a read mid-SCAN sees committed slots.
        m = '1;
        build_model(m);
        accept(m);
        step();
        check("scan_partial_count", {27'd0, bus.map_count}, LANES);
        bus.rd_en          = 1'b1;
        bus.rd_addr        = IW'(2);
        bus.in_valid       = 1'b1;
        m2 = '0; m2[0] = 1'b1;
        bus.candidate_list = m2;
        step();
        bus.in_valid = 1'b0;
        bus.rd_en    = 1'b0;
        check("scan_read", {28'd0, bus.rd_data}, 32'd2);
        check("scan_not_ready", {31'd0, bus.in_ready}, 32'd0);
        wait_done(exp_scans() - 2);
        check_table();

        // Reset in the middle of a scan.
        m = '1; m[0] = 1'b0; m[1] = 1'b0;
        accept(m);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_ready", {31'd0, bus.in_ready}, 32'd1);
        check("midrst_busy", {31'd0, bus.busy}, 32'd0);
        check("midrst_count", {27'd0, bus.map_count}, 32'd0);
        exp_q.delete();
        check_table();

        // Back-to-back: in_valid held from the DONE cycle is taken on the following IDLE edge.
        m = '0; m[3] = 1'b1; m[5] = 1'b1;
        build_model(m);
        accept(m);
        wait_done(exp_scans());
        m2 = '0; m2[0] = 1'b1; m2[8] = 1'b1; m2[10] = 1'b1; m2[11] = 1'b1; m2[14] = 1'b1;
        bus.in_valid       = 1'b1;
        bus.candidate_list = m2;
        step();
        check("b2b_idle", {31'd0, bus.in_ready}, 32'd1);
        step();
        bus.in_valid = 1'b0;
        check("b2b_accept", {31'd0, bus.busy}, 32'd1);
        build_model(m2);
        wait_done(exp_scans());
        check_table();

`ifdef CANDMAP_INVERSE_EN
        m = '0; m[2] = 1'b1; m[7] = 1'b1; m[15] = 1'b1;
        run_list(m);
        inv_check(IW'(7));
        inv_check(IW'(3));
`endif

        repeat (24) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0:       r = BS'($urandom);
                1:       r = BS'($urandom & $urandom & $urandom);
                2:       r = BS'($urandom | $urandom);
                default: r = BS'(1) << $urandom_range(0, BS - 1);
            endcase
            for (int i = 0; i < BS; i++) m[i] = r[i];
            run_list(m);
`ifdef CANDMAP_INVERSE_EN
            inv_check(IW'($urandom_range(0, BS - 1)));
            inv_check(IW'($urandom_range(0, BS - 1)));
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
